// File: rtl/bi_mem_wm_req_adapter_if.sv
// Request, response and memory-port bundle for bi_mem_wm_req_adapter.
// The slave modport is the adapter. The master modport is the requester plus memory side.
interface bi_mem_wm_req_adapter_if #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int MASK   = 4
);
  localparam int AW = $clog2(HEIGHT);

  logic             req_valid_i;
  logic             req_ready_o;
  logic             req_write_i;
  logic [MASK-1:0]  req_mask_i;
  logic [AW-1:0]    req_addr_i;
  logic [WIDTH-1:0] req_data_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] rsp_data_o;
  logic             rsp_write_o;
  logic             mem_enable_o;
  logic             mem_isWrite_o;
  logic [MASK-1:0]  mem_writeMask_o;
  logic [AW-1:0]    mem_addr_o;
  logic [WIDTH-1:0] mem_writeData_o;
  logic [WIDTH-1:0] mem_readData_i;
  logic             mem_hold_i;

  modport slave (
    input  req_valid_i, req_write_i, req_mask_i, req_addr_i, req_data_i,
           rsp_ready_i, mem_readData_i, mem_hold_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_write_o,
           mem_enable_o, mem_isWrite_o, mem_writeMask_o, mem_addr_o, mem_writeData_o
  );

  modport master (
    output req_valid_i, req_write_i, req_mask_i, req_addr_i, req_data_i,
           rsp_ready_i, mem_readData_i, mem_hold_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_write_o,
           mem_enable_o, mem_isWrite_o, mem_writeMask_o, mem_addr_o, mem_writeData_o
  );
endinterface

// File: rtl/bi_mem_wm_req_adapter.sv
// Requester front end for the write-masked single-port memory. It uses credit-limited issue
// and a response FIFO. BI_MEM_WM_REQ_ADAPTER_WRITE_ACK_EN makes writes return an ack entry.
module bi_mem_wm_req_adapter #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int MASK   = 4,
  parameter int DEPTH  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  bi_mem_wm_req_adapter_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             pending;
  logic [CW-1:0]    count;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [WIDTH-1:0] fifo_data [DEPTH];
  logic [WIDTH-1:0] last_data;
  logic [CW:0]      occ;
  logic             pop, push, accept, track, credit_ok, room, push_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign bus.mem_isWrite_o   = bus.req_write_i;
  assign bus.mem_writeMask_o = bus.req_mask_i;
  assign bus.mem_addr_o      = bus.req_addr_i;
  assign bus.mem_writeData_o = bus.req_data_i;

  // Outstanding = in flight + buffered - leaving now.
  // rsp_ready_i -> req_ready_o is a deliberate combinational path.
  assign bus.rsp_valid_o = (count != '0);
  assign pop  = bus.rsp_valid_o & bus.rsp_ready_i;
  assign push = pending;
  assign occ  = {1'b0, count} + (CW+1)'(pending) - (CW+1)'(pop);
  assign room = occ < (CW+1)'(DEPTH);

  assign bus.mem_enable_o = bus.req_valid_i & credit_ok & ~rst_i;
  assign bus.req_ready_o  = bus.mem_enable_o & ~bus.mem_hold_i;
  assign accept           = bus.req_ready_o;
  assign bus.rsp_data_o   = bus.rsp_valid_o ? fifo_data[rd_ptr] : last_data;

`ifdef BI_MEM_WM_REQ_ADAPTER_WRITE_ACK_EN
  logic pend_write, last_write;
  logic fifo_write [DEPTH];

  assign credit_ok = room;
  assign track     = accept;
  assign push_wr   = pend_write;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_write <= 1'b0;
      last_write <= 1'b0;
    end else begin
      pend_write <= accept & bus.req_write_i;
      if (pop) last_write <= fifo_write[rd_ptr];
    end
    if (push) fifo_write[wr_ptr] <= pend_write;
  end

  assign bus.rsp_write_o = bus.rsp_valid_o ? fifo_write[rd_ptr] : last_write;
`else
  assign credit_ok       = bus.req_write_i | room;
  assign track           = accept & ~bus.req_write_i;
  assign push_wr         = 1'b0;
  assign bus.rsp_write_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending   <= 1'b0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      last_data <= '0;
    end else begin
      assert (!(push && !pop && count == CW'(DEPTH)));
      pending <= track;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        last_data <= fifo_data[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Read data arrives one cycle after accept. Capture it into the tail.
  always_ff @(posedge clk_i) begin
    if (push) fifo_data[wr_ptr] <= push_wr ? '0 : bus.mem_readData_i;
  end
endmodule

// File: tb/tb_bi_mem_wm_req_adapter.sv
// Randomized and directed bench for bi_mem_wm_req_adapter. It uses a behavioural memory and a
// response queue reference that tracks when each response becomes visible.
module tb_bi_mem_wm_req_adapter;
  localparam int WIDTH = 16, HEIGHT = 16, MASK = 4, DEPTH = 2;
  localparam int AW = $clog2(HEIGHT);
  localparam int NIB = WIDTH / MASK;
`ifdef BI_MEM_WM_REQ_ADAPTER_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  bi_mem_wm_req_adapter_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .MASK(MASK)) bus();
  bi_mem_wm_req_adapter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .MASK(MASK), .DEPTH(DEPTH))
    dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  int errors = 0, checks = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] o, n, input logic [MASK-1:0] m);
    merge = o;
    for (int i = 0; i < MASK; i++)
      if (m[i]) merge[i*NIB +: NIB] = n[i*NIB +: NIB];
  endfunction

  // Behavioural memory: one-cycle read latency, honours hold, garbage on idle read bus.
  logic [WIDTH-1:0] mem [HEIGHT];
  always @(posedge clk_i) begin
    if (bus.mem_enable_o && !bus.mem_hold_i && !bus.mem_isWrite_o)
      bus.mem_readData_i <= mem[bus.mem_addr_o];
    else
      bus.mem_readData_i <= WIDTH'($urandom);
    if (bus.mem_enable_o && !bus.mem_hold_i && bus.mem_isWrite_o)
      mem[bus.mem_addr_o] <= merge(mem[bus.mem_addr_o], bus.mem_writeData_o, bus.mem_writeMask_o);
  end

  // Reference model: expected memory contents plus queue of outstanding responses.
  typedef struct { logic [WIDTH-1:0] d; logic w; int rc; } rsp_t;
  rsp_t             q[$];
  logic [WIDTH-1:0] ref_mem [HEIGHT];
  logic [WIDTH:0]   pops[$];
  logic obs_ready, obs_enable, obs_valid;
  logic [WIDTH-1:0] obs_data;

  task automatic step(input logic v, w, input logic [MASK-1:0] m, input logic [AW-1:0] a,
                      input logic [WIDTH-1:0] d, input logic rr, hold, rst);
    logic ev, pop, er, ee;
    int occ;
    @(posedge clk_i); #1;
    cyc++;
    rst_i = rst;
    bus.req_valid_i = v; bus.req_write_i = w; bus.req_mask_i = m;
    bus.req_addr_i = a; bus.req_data_i = d; bus.rsp_ready_i = rr; bus.mem_hold_i = hold;
    @(negedge clk_i);
    obs_ready = bus.req_ready_o; obs_enable = bus.mem_enable_o;
    obs_valid = bus.rsp_valid_o; obs_data = bus.rsp_data_o;
    ev  = (q.size() > 0) && (q[0].rc <= cyc);
    pop = ev && rr;
    occ = q.size() - int'(pop);
    ee  = !rst && v && ((w && !ACK) || occ < DEPTH);
    er  = ee && !hold;
    chk("rsp_valid", obs_valid, ev);
    if (ev) begin
      chk("rsp_data", obs_data, q[0].d);
      chk("rsp_write", bus.rsp_write_o, q[0].w);
    end
    chk("mem_enable", obs_enable, ee);
    chk("req_ready", obs_ready, er);
    chk("pass", {bus.mem_isWrite_o, bus.mem_writeMask_o, bus.mem_addr_o, bus.mem_writeData_o},
        {w, m, a, d});
    if (obs_valid && rr) pops.push_back({bus.rsp_write_o, obs_data});
    if (pop) void'(q.pop_front());
    if (rst) q.delete();
    else if (er) begin
      if (!w) q.push_back('{ref_mem[a], 1'b0, cyc + 2});
      else begin
        ref_mem[a] = merge(ref_mem[a], d, m);
        if (ACK) q.push_back('{'0, 1'b1, cyc + 2});
      end
    end
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 1'b0, '0, '0, '0, rr, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic rr, hold);
    step(1'b1, 1'b0, '0, a, '0, rr, hold, 1'b0);
  endtask

  initial begin
    logic pv, pw, prst;
    logic [MASK-1:0] pm;
    logic [AW-1:0] pa;
    logic [WIDTH-1:0] pd;
    for (int i = 0; i < HEIGHT; i++) begin
      mem[i] = WIDTH'(i * 16'h1111) ^ 16'h5A5A;
      ref_mem[i] = mem[i];
    end
    mem[3] = 16'hBEEF; ref_mem[3] = 16'hBEEF;
    mem[5] = 16'h1234; ref_mem[5] = 16'h1234;
    bus.req_valid_i = 0; bus.req_write_i = 0; bus.req_mask_i = '0; bus.req_addr_i = '0;
    bus.req_data_i = '0; bus.rsp_ready_i = 0; bus.mem_hold_i = 0;

    // Reset
    step(1'b1, 1'b0, '0, 4'd1, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 4'd1, '0, 1'b1, 1'b0, 1'b1);
    chk("rst_ready", obs_ready, 0);
    chk("rst_enable", obs_enable, 0);
    idle(1'b1);
    chk("rst_rsp_valid", obs_valid, 0);

    // Single read, latency 2
    pops.delete();
    rd(4'd3, 1'b1, 1'b0);  chk("t1_accept", obs_ready, 1);
    idle(1'b1);            chk("t1_n1_valid", obs_valid, 0);
    idle(1'b1);            chk("t1_n2_valid", obs_valid, 1); chk("t1_data", obs_data, 16'hBEEF);
    idle(1'b1);            chk("t1_once", obs_valid, 0);
    chk("t1_empty_hold", obs_data, 16'hBEEF);

    // Masked write, then read back
    pops.delete();
    step(1'b1, 1'b1, 4'b0011, 4'd5, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    chk("t2_wr_accept", obs_ready, 1);
    rd(4'd5, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    chk("t2_count", pops.size(), 1 + int'(ACK));
    if (pops.size() > 0) chk("t2_data", pops[pops.size()-1], {1'b0, 16'h12AA});

    // Back-to-back reads
    pops.delete();
    for (int i = 0; i < 8; i++) begin
      rd(AW'(i), 1'b1, 1'b0);
      chk("b2b_accept", obs_ready, 1);
    end
    idle(1'b1); chk("b2b_stream", obs_valid, 1);
    repeat (3) idle(1'b1);
    chk("b2b_count", pops.size(), 8);
    for (int i = 0; i < 8 && i < pops.size(); i++)
      chk("b2b_order", pops[i], {1'b0, ref_mem[i]});

    // Credit limit under back-pressure
    pops.delete();
    rd(4'd8, 1'b0, 1'b0);  chk("cr_first", obs_ready, 1);
    rd(4'd9, 1'b0, 1'b0);  chk("cr_second", obs_ready, 1);
    rd(4'd10, 1'b0, 1'b0); chk("cr_third_blocked", obs_ready, 0);
    rd(4'd10, 1'b0, 1'b0); chk("cr_third_still", obs_ready, 0);
    rd(4'd10, 1'b1, 1'b0); chk("cr_third_accept", obs_ready, 1); chk("cr_pop", obs_valid, 1);
    repeat (4) idle(1'b1);
    chk("cr_count", pops.size(), 3);

    // Memory hold
    pops.delete();
    for (int i = 0; i < 3; i++) begin
      rd(4'd11, 1'b1, 1'b1);
      chk("hold_enable", obs_enable, 1);
      chk("hold_ready", obs_ready, 0);
    end
    rd(4'd11, 1'b1, 1'b0); chk("hold_accept", obs_ready, 1);
    repeat (3) idle(1'b1);
    chk("hold_count", pops.size(), 1);
    if (pops.size() > 0) chk("hold_data", pops[0], {1'b0, ref_mem[11]});

    // Reset right after a read accept drops the response
    pops.delete();
    rd(4'd12, 1'b1, 1'b0); chk("rst_mid_accept", obs_ready, 1);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
    repeat (4) idle(1'b1);
    chk("rst_mid_dropped", pops.size(), 0);

`ifdef BI_MEM_WM_REQ_ADAPTER_WRITE_ACK_EN
    pops.delete();
    step(1'b1, 1'b1, 4'hF, 4'd7, 16'h5555, 1'b1, 1'b0, 1'b0);
    rd(4'd7, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    chk("ack_count", pops.size(), 2);
    if (pops.size() == 2) begin
      chk("ack_first", pops[0], {1'b1, 16'h0000});
      chk("ack_then_read", pops[1], {1'b0, 16'h5555});
    end
`endif

    // Random traffic. A pending request stays stable until it is accepted.
    pv = 0; pw = 0; pm = '0; pa = '0; pd = '0; prst = 0;
    for (int n = 0; n < 400; n++) begin
      logic rr, hold, rst;
      if (!(pv && !obs_ready && !prst)) begin
        pv = ($urandom_range(0, 3) != 0);
        pw = $urandom_range(0, 2) == 0;
        pm = MASK'($urandom);
        pa = AW'($urandom);
        pd = WIDTH'($urandom);
      end
      rr   = ($urandom_range(0, 9) < 7);
      hold = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      prst = rst;
      step(pv, pw, pm, pa, pd, rr, hold, rst);
    end
    repeat (4) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bi_mem_wm_req_adapter.md
Name: bi_mem_wm_req_adapter

Overview:
- Requester-side front end for the write-masked single-port memory wrapper.
- Converts a valid/ready request channel and a valid/ready read-response channel into the memory's enable/isWrite/mask/addr port.
- Honours the memory's hold (stall) output and captures one-cycle-latency read data into a small response FIFO, so the requester may apply back-pressure.

Parameters:
- WIDTH, 16, data width; equals the memory WIDTH.
- HEIGHT, 16, word count; address width is $clog2(HEIGHT).
- MASK, 4, write-mask width; equals the memory MASK.
- DEPTH, 2, response FIFO entries (minimum 2); also the cap on outstanding responses.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted this cycle when high together with req_valid_i.
- req_write_i  in  1  1 = write, 0 = read.
- req_mask_i  in  MASK  write mask.
- req_addr_i  in  $clog2(HEIGHT)  word address.
- req_data_i  in  WIDTH  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_data_o  out  WIDTH  read data (0 for write acks).
- rsp_write_o  out  1  response is a write ack.
- mem_enable_o  out  1  to memory enable_i.
- mem_isWrite_o  out  1  to memory isWrite_i.
- mem_writeMask_o  out  MASK  to memory writeMask_i.
- mem_addr_o  out  $clog2(HEIGHT)  to memory addr_i.
- mem_writeData_o  out  WIDTH  to memory writeData_i.
- mem_readData_i  in  WIDTH  from memory readData_o.
- mem_hold_i  in  1  from memory hold_o.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous, active-high, on rst_i.
- Reset values:
  - rsp_valid_o=0; FIFO empty; pending flag cleared.
  - req_ready_o=0 and mem_enable_o=0 while rst_i=1.
- Memory-side pass-through:
  - mem_isWrite_o, mem_writeMask_o, mem_addr_o and mem_writeData_o are driven combinationally from the req_* inputs (zero latency).
- Credit rule:
  - occ = pending + fifo_count − pop, where pop = rsp_valid_o & rsp_ready_i.
  - Reads always need a credit. Writes need one only with the macro on.
  - credit_ok = (occ < DEPTH) or (request is a write without the macro).
- Handshake:
  - mem_enable_o = req_valid_i & credit_ok & ~rst_i.
  - req_ready_o = mem_enable_o & ~mem_hold_i.
  - An access is performed only in a cycle where mem_enable_o=1 and mem_hold_i=0 (accept).
  - While the memory holds, the requester keeps the req_* inputs stable (valid/ready rule). The adapter repeats the enable every cycle until the hold clears.
- Read latency:
  - A read accepted in cycle N sets pending for cycle N+1.
  - In cycle N+1, mem_readData_i is sampled into the FIFO tail.
  - rsp_valid_o goes high from cycle N+2.
  - Back-to-back reads with rsp_ready_i=1 sustain one request per cycle.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a count.
  - Push and pop in the same cycle leave the count unchanged.
  - rsp_data_o and rsp_write_o come from the head entry.
  - Overflow is impossible by credit rule; a simulation assertion fires on push while full.
- Empty FIFO: rsp_valid_o=0; rsp_data_o holds its last value.
- Combinational path rsp_ready_i → req_ready_o is intentional and documented for timing.
- Reset mid-operation: any pending read is dropped; data on mem_readData_i in the cycle after reset is ignored; FIFO contents are discarded.
- No state machine beyond the pending flag and the FIFO pointers.

Optional Feature:
- Macro: BI_MEM_WM_REQ_ADAPTER_WRITE_ACK_EN.
- Defined:
  - Each accepted write consumes a credit.
  - One cycle later it pushes an entry {rsp_write_o=1, rsp_data_o=0}, ordered with reads.
- Undefined:
  - Writes need no credit and produce no response.
  - rsp_write_o is tied 0.
  - Writes are accepted even when the FIFO is full.

Test Plan:
- Reset, then read addr 3 holding 0xBEEF with rsp_ready_i=1 → req_ready_o=1 at N; rsp_valid_o=1, rsp_data_o=0xBEEF at N+2 for one cycle.
- Write 0xAAAA to addr 5 with mask 4'b0011, then read addr 5 (old value 0x1234) → response 0x12AA; no response for the write (macro off).
- Reads addr 0..7 back-to-back with rsp_ready_i=1 → one accept per cycle, eight responses in order on consecutive cycles.
- rsp_ready_i=0, issue 3 reads → first two accepted, third sees req_ready_o=0. Raise rsp_ready_i → third is accepted in the same cycle as the first pop.
- mem_hold_i=1 for 3 cycles during a read → mem_enable_o=1 and req_ready_o=0 for 3 cycles; accept on the 4th; exactly one response.
- Assert rst_i the cycle after a read accept → no response ever appears. With the macro on, write then read → write ack (rsp_write_o=1) precedes the read data.
